kv_cache_ring: RTL and testbench
================================

KV_CACHE_RING -- requirements
Module: kv_cache_ring

Interface
REQ-001 SHALL have parameter N_LAYERS, default 4, number of transformer layers.
REQ-002 SHALL have parameter N_HEADS, default 8, heads per layer (power of two).
REQ-003 SHALL have parameter HEAD_DIM, default 16, dimensions per head (power of two).
REQ-004 SHALL have parameter MAX_POS, default 256, ring depth in positions (power of two).
REQ-005 SHALL have parameter DATA_W, default 8, element width in bits.
REQ-006 SHALL have port clk_i, input, 1, single clock; all logic on rising edge.
REQ-007 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-008 SHALL have port clear_i, input, 1, drop all cached tokens, all layers.
REQ-009 SHALL have port wr_en_i, input, 1, write one element.
REQ-010 SHALL have ports wr_layer_i, wr_kv_sel_i, wr_head_i, wr_dim_i, inputs, clog2 widths (kv_sel 1 bit), write element select.
REQ-011 SHALL have port wr_data_i, input, DATA_W, write element data.
REQ-012 SHALL have ports commit_i, input, 1, and commit_layer_i, input, clog2(N_LAYERS), which close the current token of one layer.
REQ-013 SHALL have ports rd_en_i, rd_layer_i, rd_kv_sel_i, rd_head_i, rd_dim_i, inputs, read request and element select.
REQ-014 SHALL have port rd_pos_i, input, clog2(MAX_POS), logical position, 0 = oldest cached token.
REQ-015 SHALL have ports rd_valid_o, output, 1; rd_data_o, output, DATA_W; rd_err_o, output, 1: read response.
REQ-016 SHALL have port count_o, output, N_LAYERS*(clog2(MAX_POS)+1), per-layer fill count; layer L is at bits [L*W +: W].

Function
REQ-017 SHALL store N_LAYERS*2*N_HEADS banks of MAX_POS*HEAD_DIM elements, addressed by bank {layer, kv_sel, head} and word {phys_pos, dim}.
REQ-018 SHALL keep a wr_ptr (clog2(MAX_POS) bits) and a count (0..MAX_POS) for each layer.
REQ-019 SHALL write wr_data_i at phys_pos = wr_ptr[wr_layer_i] when wr_en_i is high; writes do not move any pointer.
REQ-020 SHALL, on commit_i, advance wr_ptr[commit_layer_i] by 1 modulo MAX_POS and increment its count, saturating at MAX_POS.
REQ-021 SHALL, once count = MAX_POS, overwrite the oldest token on later writes to that layer (sliding window); count stays MAX_POS.
REQ-022 SHALL map a read to phys_pos = (wr_ptr - count + rd_pos_i) modulo MAX_POS, using the layer's pre-edge wr_ptr and count.
REQ-023 SHALL assert rd_valid_o exactly 2 cycles after each cycle with rd_en_i high; reads are fully pipelined, one per cycle, with no stall.
REQ-024 SHALL, when rd_pos_i >= count at request time, return rd_data_o = 0 and rd_err_o = 1 together with rd_valid_o.
REQ-025 SHALL hold rd_data_o and rd_err_o at 0 whenever rd_valid_o is 0.
REQ-026 SHALL return the old stored data when a read and a write hit the same element in the same cycle.
REQ-027 SHALL, for a write and a commit on the same layer in the same cycle, store the write at the pre-commit wr_ptr.
REQ-028 SHALL, on clear_i, zero every wr_ptr and count on the next edge and leave memory contents undefined-but-unchanged; clear_i has priority over a simultaneous commit_i.
REQ-029 SHALL, when wr_en_i and clear_i coincide, still perform the write at the pre-clear wr_ptr.
REQ-030 SHALL complete read responses already in flight during clear_i, using the mapping captured at request time.

Reset
REQ-031 SHALL, on rst_i high at a clock edge, zero all wr_ptr, count, count_o, rd_valid_o, rd_data_o, rd_err_o and the read pipeline; memory contents are not reset.
REQ-032 SHALL discard any read in flight when rst_i is asserted; no rd_valid_o follows within 2 cycles of reset.
REQ-033 SHALL accept a request on the first edge after rst_i deasserts.

Verification
REQ-034 Basic: on layer 0 write K head 2 dim 5 = 0x3C, commit, then read pos 0 -> rd_valid_o 2 cycles later, data 0x3C, err 0, count 1.
REQ-035 Out of range: with count 1, read pos 1 -> rd_err_o 1, data 0; with count 0 after clear, read pos 0 -> err 1.
REQ-036 Wrap: commit 258 tokens on layer 1 with token t storing t[7:0] in V head 0 dim 0 -> count 256; pos 0 reads 0x02; pos 255 reads 0x01 (token 257).
REQ-037 Simultaneous: write and commit on the same layer in one cycle -> data appears at the old pointer; commit and clear together -> count 0.
REQ-038 Pipeline: 8 back-to-back reads -> 8 consecutive rd_valid_o pulses, in order, at a fixed 2-cycle offset.
REQ-039 Reset mid-read: rst_i asserted one cycle after rd_en_i -> no rd_valid_o; all count_o fields read 0.

Source files
------------

// File: rtl/kv_cache_if.sv
// Request/response bundle for kv_cache_ring: element write, token commit, clear,
// and the pipelined read port with per-layer fill counts.
interface kv_cache_if #(
    parameter int N_LAYERS = 4,
    parameter int N_HEADS  = 8,
    parameter int HEAD_DIM = 16,
    parameter int MAX_POS  = 256,
    parameter int DATA_W   = 8
);
    localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int HW = (N_HEADS  > 1) ? $clog2(N_HEADS)  : 1;
    localparam int DW = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
    localparam int PW = (MAX_POS  > 1) ? $clog2(MAX_POS)  : 1;
    localparam int CW = PW + 1;

    logic                   clear_i;
    logic                   wr_en_i;
    logic [LW-1:0]          wr_layer_i;
    logic                   wr_kv_sel_i;
    logic [HW-1:0]          wr_head_i;
    logic [DW-1:0]          wr_dim_i;
    logic [DATA_W-1:0]      wr_data_i;
    logic                   commit_i;
    logic [LW-1:0]          commit_layer_i;
    logic                   rd_en_i;
    logic [LW-1:0]          rd_layer_i;
    logic                   rd_kv_sel_i;
    logic [HW-1:0]          rd_head_i;
    logic [DW-1:0]          rd_dim_i;
    logic [PW-1:0]          rd_pos_i;
    logic                   rd_valid_o;
    logic [DATA_W-1:0]      rd_data_o;
    logic                   rd_err_o;
    logic [N_LAYERS*CW-1:0] count_o;

    modport master (
        output clear_i, wr_en_i, wr_layer_i, wr_kv_sel_i, wr_head_i, wr_dim_i, wr_data_i,
        output commit_i, commit_layer_i,
        output rd_en_i, rd_layer_i, rd_kv_sel_i, rd_head_i, rd_dim_i, rd_pos_i,
        input  rd_valid_o, rd_data_o, rd_err_o, count_o
    );

    modport slave (
        input  clear_i, wr_en_i, wr_layer_i, wr_kv_sel_i, wr_head_i, wr_dim_i, wr_data_i,
        input  commit_i, commit_layer_i,
        input  rd_en_i, rd_layer_i, rd_kv_sel_i, rd_head_i, rd_dim_i, rd_pos_i,
        output rd_valid_o, rd_data_o, rd_err_o, count_o
    );
endinterface

// File: rtl/kv_cache_ring.sv
// Per-layer ring-buffer KV cache: sliding window of MAX_POS tokens per layer,
// element-granular writes, token commit, and a 2-stage read pipeline.
module kv_cache_ring #(
    parameter int N_LAYERS = 4,
    parameter int N_HEADS  = 8,
    parameter int HEAD_DIM = 16,
    parameter int MAX_POS  = 256,
    parameter int DATA_W   = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    kv_cache_if.slave  bus
);
    localparam int LW    = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
    localparam int HW    = (N_HEADS  > 1) ? $clog2(N_HEADS)  : 1;
    localparam int DW    = (HEAD_DIM > 1) ? $clog2(HEAD_DIM) : 1;
    localparam int PW    = (MAX_POS  > 1) ? $clog2(MAX_POS)  : 1;
    localparam int CW    = PW + 1;
    localparam int AW    = LW + 1 + HW + PW + DW;
    localparam int DEPTH = 1 << AW;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(MAX_POS);

    logic [DATA_W-1:0]      mem_r [DEPTH];
    logic [PW-1:0]          wr_ptr_r [N_LAYERS];
    logic [CW-1:0]          count_r  [N_LAYERS];

    logic [PW-1:0]          wr_phys_s;
    logic [PW-1:0]          rd_phys_s;
    logic [AW-1:0]          wr_addr_s;
    logic [AW-1:0]          rd_addr_s;
    logic                   rd_oob_s;
    logic [N_LAYERS*CW-1:0] count_flat_s;

    logic                   rd_v1_r;
    logic                   rd_err1_r;
    logic [DATA_W-1:0]      rd_mem_r;

    // Address generation; a full ring has count mod MAX_POS = 0, so oldest = wr_ptr
    always_comb begin
        wr_phys_s = wr_ptr_r[bus.wr_layer_i];
        rd_phys_s = wr_ptr_r[bus.rd_layer_i] - count_r[bus.rd_layer_i][PW-1:0] + bus.rd_pos_i;
        rd_oob_s  = ({1'b0, bus.rd_pos_i} >= count_r[bus.rd_layer_i]);
        wr_addr_s = {bus.wr_layer_i, bus.wr_kv_sel_i, bus.wr_head_i, wr_phys_s, bus.wr_dim_i};
        rd_addr_s = {bus.rd_layer_i, bus.rd_kv_sel_i, bus.rd_head_i, rd_phys_s, bus.rd_dim_i};
    end

    // Flatten the per-layer fill counts onto the count bus
    always_comb begin
        count_flat_s = '0;
        for (int l = 0; l < N_LAYERS; l++) begin
            count_flat_s[l*CW +: CW] = count_r[l];
        end
    end

    assign bus.count_o = count_flat_s;

    // Ring pointer and saturating fill count per layer; clear outranks commit
    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            for (int l = 0; l < N_LAYERS; l++) begin
                wr_ptr_r[l] <= '0;
                count_r[l]  <= '0;
            end
        end else if (bus.commit_i) begin
            wr_ptr_r[bus.commit_layer_i] <= wr_ptr_r[bus.commit_layer_i] + PTR_ONE;
            if (count_r[bus.commit_layer_i] != CNT_FULL) begin
                count_r[bus.commit_layer_i] <= count_r[bus.commit_layer_i] + CNT_ONE;
            end
        end
    end

    // Element storage; the read samples pre-write contents on a same-address hit
    always_ff @(posedge clk_i) begin
        if (bus.wr_en_i) begin
            mem_r[wr_addr_s] <= bus.wr_data_i;
        end
        rd_mem_r <= mem_r[rd_addr_s];
    end

    // Read response pipeline: stage 1 holds the request, stage 2 drives the outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_v1_r        <= 1'b0;
            rd_err1_r      <= 1'b0;
            bus.rd_valid_o <= 1'b0;
            bus.rd_err_o   <= 1'b0;
            bus.rd_data_o  <= '0;
        end else begin
            rd_v1_r        <= bus.rd_en_i;
            rd_err1_r      <= bus.rd_en_i & rd_oob_s;
            bus.rd_valid_o <= rd_v1_r;
            bus.rd_err_o   <= rd_v1_r & rd_err1_r;
            bus.rd_data_o  <= (rd_v1_r && !rd_err1_r) ? rd_mem_r : '0;
        end
    end
endmodule

// File: tb/tb_kv_cache_ring.sv
// Self-checking bench for kv_cache_ring: directed vector table, multi-cycle corner
// sequences and a randomized phase against a token-history reference model.
module tb_kv_cache_ring;
    localparam int N_LAYERS = 4;
    localparam int N_HEADS  = 8;
    localparam int HEAD_DIM = 16;
    localparam int MAX_POS  = 256;
    localparam int DATA_W   = 8;
    localparam int CW       = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    kv_cache_if #(.N_LAYERS(N_LAYERS), .N_HEADS(N_HEADS), .HEAD_DIM(HEAD_DIM),
                  .MAX_POS(MAX_POS), .DATA_W(DATA_W)) bus ();

    kv_cache_ring #(.N_LAYERS(N_LAYERS), .N_HEADS(N_HEADS), .HEAD_DIM(HEAD_DIM),
                    .MAX_POS(MAX_POS), .DATA_W(DATA_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every token ever opened on a layer has an id; the physical
    // slot of id is id mod MAX_POS (clear/reset jump to the next multiple).
    typedef struct {
        bit         v;
        bit         err;
        bit         known;
        logic [7:0] data;
    } resp_t;

    int          open_id [N_LAYERS];
    int          cnt_m   [N_LAYERS];
    logic [7:0]  store   [bit [63:0]];
    resp_t       s1, s2;

    function automatic resp_t no_resp();
        resp_t r;
        r.v = 1'b0; r.err = 1'b0; r.known = 1'b1; r.data = 8'h00;
        return r;
    endfunction

    function automatic bit [63:0] key(int l, int id, int kv, int h, int d);
        return {8'(l), 32'(id), 8'(kv), 8'(h), 8'(d)};
    endfunction

    // A cached slot holds whatever the latest token mapped to it wrote.
    function automatic resp_t model_read(int l, int kv, int h, int d, int pos);
        resp_t r;
        int    t;
        int    id;
        r = no_resp();
        r.v = 1'b1;
        if (pos >= cnt_m[l]) begin
            r.err = 1'b1;
            return r;
        end
        r.known = 1'b0;
        t  = open_id[l] - cnt_m[l] + pos;
        id = t + ((open_id[l] - t) / MAX_POS) * MAX_POS;
        while (id >= 0) begin
            if (store.exists(key(l, id, kv, h, d))) begin
                r.known = 1'b1;
                r.data  = store[key(l, id, kv, h, d)];
                break;
            end
            id -= MAX_POS;
        end
        return r;
    endfunction

    task automatic idle();
        bus.clear_i = 1'b0;  bus.wr_en_i = 1'b0; bus.wr_layer_i = 2'd0; bus.wr_kv_sel_i = 1'b0;
        bus.wr_head_i = 3'd0; bus.wr_dim_i = 4'd0; bus.wr_data_i = 8'h00;
        bus.commit_i = 1'b0; bus.commit_layer_i = 2'd0;
        bus.rd_en_i = 1'b0;  bus.rd_layer_i = 2'd0; bus.rd_kv_sel_i = 1'b0;
        bus.rd_head_i = 3'd0; bus.rd_dim_i = 4'd0; bus.rd_pos_i = 8'd0;
    endtask

    task automatic set_rd(input int l, input int kv, input int h, input int d, input int p);
        bus.rd_en_i = 1'b1; bus.rd_layer_i = 2'(l); bus.rd_kv_sel_i = 1'(kv);
        bus.rd_head_i = 3'(h); bus.rd_dim_i = 4'(d); bus.rd_pos_i = 8'(p);
    endtask

    task automatic set_wr(input int l, input int kv, input int h, input int d, input int v);
        bus.wr_en_i = 1'b1; bus.wr_layer_i = 2'(l); bus.wr_kv_sel_i = 1'(kv);
        bus.wr_head_i = 3'(h); bus.wr_dim_i = 4'(d); bus.wr_data_i = 8'(v);
    endtask

    // One clock: update the model with the driven inputs, then check all outputs.
    task automatic tick();
        resp_t nr;
        nr = no_resp();
        if (bus.rd_en_i && !rst)
            nr = model_read(int'(bus.rd_layer_i), int'(bus.rd_kv_sel_i), int'(bus.rd_head_i),
                            int'(bus.rd_dim_i), int'(bus.rd_pos_i));
        if (bus.wr_en_i)
            store[key(int'(bus.wr_layer_i), open_id[bus.wr_layer_i], int'(bus.wr_kv_sel_i),
                      int'(bus.wr_head_i), int'(bus.wr_dim_i))] = bus.wr_data_i;
        if (rst || bus.clear_i) begin
            for (int l = 0; l < N_LAYERS; l++) begin
                open_id[l] = (open_id[l] / MAX_POS + 1) * MAX_POS;
                cnt_m[l]   = 0;
            end
        end else if (bus.commit_i) begin
            open_id[bus.commit_layer_i]++;
            if (cnt_m[bus.commit_layer_i] < MAX_POS) cnt_m[bus.commit_layer_i]++;
        end
        s2 = s1;
        s1 = nr;
        if (rst) begin
            s1 = no_resp();
            s2 = no_resp();
        end
        @(posedge clk);
        #1;
        check("rd_valid", 32'(bus.rd_valid_o), 32'(s2.v));
        check("rd_err", 32'(bus.rd_err_o), 32'(s2.err));
        if (s2.known) check("rd_data", 32'(bus.rd_data_o), 32'(s2.data));
        for (int l = 0; l < N_LAYERS; l++)
            check("count", 32'(bus.count_o[l*CW +: CW]), 32'(cnt_m[l]));
    endtask

    typedef struct {
        int clr, we, wl, wkv, wh, wd, wdata, cm, cl;
        int re, rl, rkv, rh, rd, rp;
        int ev, ee, ed, ec0;
    } vec_t;

    vec_t vt [11];

    initial begin
        for (int l = 0; l < N_LAYERS; l++) begin
            open_id[l] = 0;
            cnt_m[l]   = 0;
        end
        s1 = no_resp();
        s2 = no_resp();

        //        clr we wl kv wh wd wdat  cm cl  re rl kv rh rd rp  ev ee ed    c0
        vt[0]  = '{0, 1, 0, 0, 2, 5, 'h3C, 0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,    0};
        vt[1]  = '{0, 0, 0, 0, 0, 0, 0,    1, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,    1};
        vt[2]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  1, 0, 0, 2, 5, 0,  0, 0, 0,    1};
        vt[3]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  1, 0, 0, 2, 5, 1,  1, 0, 'h3C, 1};
        vt[4]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0,    1};
        vt[5]  = '{1, 0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,    0};
        vt[6]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  1, 0, 0, 2, 5, 0,  0, 0, 0,    0};
        vt[7]  = '{0, 1, 0, 1, 1, 3, 'hA5, 1, 0,  0, 0, 0, 0, 0, 0,  1, 1, 0,    1};
        vt[8]  = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  1, 0, 1, 1, 3, 0,  0, 0, 0,    1};
        vt[9]  = '{1, 0, 0, 0, 0, 0, 0,    1, 0,  0, 0, 0, 0, 0, 0,  1, 0, 'hA5, 0};
        vt[10] = '{0, 0, 0, 0, 0, 0, 0,    0, 0,  0, 0, 0, 0, 0, 0,  0, 0, 0,    0};

        idle();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Directed table: basic write/commit/read, out-of-range, clear, same-cycle cases
        for (int i = 0; i < 11; i++) begin
            idle();
            bus.clear_i = 1'(vt[i].clr);
            if (vt[i].we != 0) set_wr(vt[i].wl, vt[i].wkv, vt[i].wh, vt[i].wd, vt[i].wdata);
            bus.commit_i = 1'(vt[i].cm);
            bus.commit_layer_i = 2'(vt[i].cl);
            if (vt[i].re != 0) set_rd(vt[i].rl, vt[i].rkv, vt[i].rh, vt[i].rd, vt[i].rp);
            tick();
            check($sformatf("tbl%0d_valid", i), 32'(bus.rd_valid_o), 32'(vt[i].ev));
            check($sformatf("tbl%0d_err", i), 32'(bus.rd_err_o), 32'(vt[i].ee));
            check($sformatf("tbl%0d_data", i), 32'(bus.rd_data_o), 32'(vt[i].ed));
            check($sformatf("tbl%0d_count0", i), 32'(bus.count_o[0 +: CW]), 32'(vt[i].ec0));
        end

        // Wrap: 258 tokens on layer 1, token t stores t[7:0] in V head 0 dim 0
        for (int t = 0; t < 258; t++) begin
            idle();
            set_wr(1, 1, 0, 0, t % 256);
            bus.commit_i = 1'b1;
            bus.commit_layer_i = 2'd1;
            tick();
        end
        check("wrap_count", 32'(bus.count_o[CW +: CW]), 32'd256);
        idle(); set_rd(1, 1, 0, 0, 0);   tick();
        idle(); set_rd(1, 1, 0, 0, 255); tick();
        check("wrap_pos0", 32'(bus.rd_data_o), 32'h02);
        idle(); tick();
        check("wrap_pos255", 32'(bus.rd_data_o), 32'h01);
        check("wrap_pos255_err", 32'(bus.rd_err_o), 32'd0);

        // Eight back-to-back reads: consecutive pulses, in order, fixed offset
        for (int i = 0; i < 10; i++) begin
            idle();
            if (i < 8) set_rd(1, 1, 0, 0, i);
            tick();
            check($sformatf("pipe%0d_valid", i), 32'(bus.rd_valid_o), (i >= 1 && i <= 8) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= 8)
                check($sformatf("pipe%0d_data", i), 32'(bus.rd_data_o), 32'(i + 1));
        end

        // Read and write of the same element in one cycle returns the old value
        idle(); set_rd(1, 1, 0, 0, 0); set_wr(1, 1, 0, 0, 'h77); tick();
        idle(); set_rd(1, 1, 0, 0, 0); tick();
        check("raw_old", 32'(bus.rd_data_o), 32'h02);
        idle(); tick();
        check("raw_new", 32'(bus.rd_data_o), 32'h77);

        // Reset one cycle after a read request: the response is dropped
        idle(); set_rd(1, 1, 0, 0, 0); tick();
        idle(); rst = 1'b1; tick();
        rst = 1'b0;
        check("rst_valid0", 32'(bus.rd_valid_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            idle(); tick();
            check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
            check("rst_counts", 32'(bus.count_o == '0), 32'd1);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            int rl;
            idle();
            rst = ($urandom_range(0, 499) == 0);
            bus.clear_i = 1'($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 1) == 1)
                set_wr(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            bus.commit_i = 1'($urandom_range(0, 2) == 0);
            bus.commit_layer_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                rl = int'($urandom_range(0, 3));
                set_rd(rl, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                                   : int'($urandom_range(0, (cnt_m[rl] > 255) ? 255 : cnt_m[rl])));
            end
            tick();
        end
        rst = 1'b0;
        idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
